// File: rtl/slc3_pkg.sv
// Shared types and encodings for the SLC-3 instruction sequencer.
// The PAUSE states exist only when SLC3_PAUSE_EN is defined.
package slc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_18, S_33, S_35, S_32,
    S_00, S_01, S_04, S_05, S_06, S_07, S_09, S_12,
    S_16, S_21, S_22, S_23, S_25, S_27
`ifdef SLC3_PAUSE_EN
    , S_PAUSE_IR1, S_PAUSE_IR2
`endif
  } state_e;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

endpackage

// File: rtl/slc3_wait_counter.sv
// SRAM wait-cycle counter: done flags the last of MEM_CYCLES access cycles.
module slc3_wait_counter #(
  parameter int MEM_CYCLES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [2:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable)
      count_d = count_q + 3'd1;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign done = (count_q == 3'(MEM_CYCLES - 1));

endmodule

// File: rtl/slc3_isdu.sv
// SLC-3 multicycle fetch/decode/execute sequencer with SRAM wait insertion.
// Optional PAUSE instruction (opcode 1101) is built when SLC3_PAUSE_EN is defined.
module slc3_isdu
  import slc3_pkg::*;
#(
  parameter int MEM_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  state_e state_q;
  logic   inWait;
  logic   memDone;

  // The counter idles at zero outside the three access states, so every entry starts fresh.
  assign inWait = (state_q == S_33) || (state_q == S_25) || (state_q == S_16);

  slc3_wait_counter #(.MEM_CYCLES(MEM_CYCLES)) u_wait (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (!inWait),
    .enable (inWait),
    .done   (memDone)
  );

`ifdef SLC3_PAUSE_EN
  logic pauseFirst_q;
`else
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_HALTED;
`ifdef SLC3_PAUSE_EN
      pauseFirst_q <= 1'b0;
`endif
    end else begin
`ifdef SLC3_PAUSE_EN
      pauseFirst_q <= (state_q == S_32) && (Opcode == OP_PSE);
`endif
      case (state_q)
        S_HALTED: if (Run) state_q <= S_18;
        S_18:     state_q <= S_33;
        S_33:     if (memDone) state_q <= S_35;
        S_35:     state_q <= S_32;
        S_32: begin
          case (Opcode)
            OP_ADD:  state_q <= S_01;
            OP_AND:  state_q <= S_05;
            OP_NOT:  state_q <= S_09;
            OP_BR:   state_q <= S_00;
            OP_JMP:  state_q <= S_12;
            OP_JSR:  state_q <= S_04;
            OP_LDR:  state_q <= S_06;
            OP_STR:  state_q <= S_07;
`ifdef SLC3_PAUSE_EN
            OP_PSE:  state_q <= S_PAUSE_IR1;
`endif
            default: state_q <= S_18;
          endcase
        end
        S_00:     state_q <= BEN ? S_22 : S_18;
        S_04:     state_q <= S_21;
        S_06:     state_q <= S_25;
        S_25:     if (memDone) state_q <= S_27;
        S_07:     state_q <= S_23;
        S_23:     state_q <= S_16;
        S_16:     if (memDone) state_q <= S_18;
`ifdef SLC3_PAUSE_EN
        S_PAUSE_IR1: if (Continue) state_q <= S_PAUSE_IR2;
        S_PAUSE_IR2: if (!Continue) state_q <= S_18;
`endif
        S_01, S_05, S_09, S_12, S_21, S_22, S_27: state_q <= S_18;
        default:  state_q <= S_HALTED;
      endcase
    end
  end

  // Control word decode; only SR2MUX follows IR_5 in the ALU states.
  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_PC1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_ZERO; ALUK = ALUK_ADD;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_q)
      S_18: begin GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_PC1; LD_PC = 1'b1; end
      S_33, S_25: begin Mem_OE = 1'b0; LD_MDR = memDone; end
      S_35: begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_32: LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; GateALU = 1'b1;
        LD_REG = 1'b1; LD_CC = 1'b1; DRMUX = 1'b0;
        ALUK = (state_q == S_01) ? ALUK_ADD : (state_q == S_05) ? ALUK_AND : ALUK_NOT;
      end
      S_22: begin ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_12: begin
        ADDR1MUX = 1'b1; SR1MUX = 1'b1; ADDR2MUX = ADDR2_ZERO;
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
      end
      S_04: begin GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1; end
      S_21: begin ADDR1MUX = 1'b0; ADDR2MUX = ADDR2_OFF11; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_06, S_07: begin
        ADDR1MUX = 1'b1; SR1MUX = 1'b1; ADDR2MUX = ADDR2_OFF6;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S_27: begin GateMDR = 1'b1; DRMUX = 1'b0; LD_REG = 1'b1; LD_CC = 1'b1; end
      S_23: begin SR1MUX = 1'b0; ALUK = ALUK_PASSA; GateALU = 1'b1; LD_MDR = 1'b1; end
      S_16: Mem_WE = 1'b0;
`ifdef SLC3_PAUSE_EN
      S_PAUSE_IR1: LD_LED = pauseFirst_q;
`endif
      default: ;
    endcase
  end

endmodule
